rtc_edit_sequencer: RTL and testbench

// Top-level sequencer for the time/date holding registers (hours, minutes, seconds...).
// In run mode it periodically requests an RTC read and pulses ACTUALIZAR so every register reloads.
// In edit mode it owns field selection (one-hot MODIFICANDO), generates debounced, auto-repeating UP/DOWN pulses,
// and on exit requests an RTC write of the edited values, then forces a resync read.

---
 rtl/rtc_edit_sequencer_if.sv | 39 +++
 rtl/rtc_edit_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_rtc_edit_sequencer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_edit_sequencer_if.sv
// Bundle of handshake and button signals around rtc_edit_sequencer.
//   master : the sequencer (receives buttons and bus-controller acks,
//            drives requests, reload pulse, field select and edit strobes)
//   slave  : the environment (buttons + RTC bus controller + registers)
// Signals:
//   BTN_EDIT, BTN_NEXT, BTN_UP, BTN_DOWN  debounced button levels
//   RD_DONE, WR_ACK                       RTC bus controller completion
//   RD_REQ, WR_REQ                        held requests to the bus controller
//   ACTUALIZAR                            one-cycle register reload strobe
//   MODIFICANDO[N_FIELDS-1:0]             one-hot field being edited
//   UP_PULSE, DOWN_PULSE                  one-cycle increment/decrement strobes
//   EDITING                               display blink enable
interface rtc_edit_sequencer_if #(
  parameter int unsigned N_FIELDS = 3
);
  logic                BTN_EDIT;
  logic                BTN_NEXT;
  logic                BTN_UP;
  logic                BTN_DOWN;
  logic                RD_DONE;
  logic                WR_ACK;
  logic                RD_REQ;
  logic                WR_REQ;
  logic                ACTUALIZAR;
  logic [N_FIELDS-1:0] MODIFICANDO;
  logic                UP_PULSE;
  logic                DOWN_PULSE;
  logic                EDITING;

  modport master (
    input  BTN_EDIT, BTN_NEXT, BTN_UP, BTN_DOWN, RD_DONE, WR_ACK,
    output RD_REQ, WR_REQ, ACTUALIZAR, MODIFICANDO, UP_PULSE, DOWN_PULSE, EDITING
  );

  modport slave (
    output BTN_EDIT, BTN_NEXT, BTN_UP, BTN_DOWN, RD_DONE, WR_ACK,
    input  RD_REQ, WR_REQ, ACTUALIZAR, MODIFICANDO, UP_PULSE, DOWN_PULSE, EDITING
  );
endinterface

// File: rtl/rtc_edit_sequencer.sv
// Sequencer for the time/date holding registers.
// Run mode: periodically requests an RTC read and pulses ACTUALIZAR so every
// register reloads. Edit mode: owns the one-hot field select, produces
// auto-repeating UP/DOWN strobes, and on exit requests an RTC write followed
// by a resync read. An idle edit session times out into a read, which
// discards the edits by reloading the registers.
// Ports:
//   CLK      system clock, rising edge
//   RESET_n  synchronous reset, active low
//   bus      rtc_edit_sequencer_if master modport (buttons, RTC handshake,
//            ACTUALIZAR, MODIFICANDO, UP/DOWN strobes, EDITING)
module rtc_edit_sequencer #(
  parameter int unsigned N_FIELDS       = 3,
  parameter int unsigned REFRESH_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES    = 1048576,
  parameter int unsigned EDIT_TIMEOUT   = 268435456
) (
  input logic                  CLK,
  input logic                  RESET_n,
  rtc_edit_sequencer_if.master bus
);

  localparam int unsigned REF_W  = $clog2(REFRESH_CYCLES);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES);
  localparam int unsigned TMO_W  = $clog2(EDIT_TIMEOUT);
  localparam int unsigned SEL_W  = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;

  localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(EDIT_TIMEOUT - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(N_FIELDS - 1);

  localparam int unsigned B_EDIT = 0;
  localparam int unsigned B_NEXT = 1;
  localparam int unsigned B_UP   = 2;
  localparam int unsigned B_DOWN = 3;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EDIT,
    COMMIT
  } state_t;

  state_t              state_q, state_d;
  logic [REF_W-1:0]    refresh_q, refresh_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [TMO_W-1:0]    timeout_q, timeout_d;
  logic                pending_q, pending_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [3:0]          btn_q, btn_d;
  logic [3:0]          btn_prev_q, btn_prev_d;

  logic                rd_req_q, rd_req_d;
  logic                wr_req_q, wr_req_d;
  logic                actualizar_q, actualizar_d;
  logic [N_FIELDS-1:0] modificando_q, modificando_d;
  logic                up_pulse_q, up_pulse_d;
  logic                down_pulse_q, down_pulse_d;
  logic                editing_q, editing_d;

  logic [3:0]          btn_rise;
  logic                up_only;
  logic                down_only;
  logic                activity;
  logic                dir_rise;
  logic                rep_fire;

  always_comb begin
    btn_d      = {bus.BTN_DOWN, bus.BTN_UP, bus.BTN_NEXT, bus.BTN_EDIT};
    btn_prev_d = btn_q;
    btn_rise   = btn_q & ~btn_prev_q;
    up_only    = btn_q[B_UP] & ~btn_q[B_DOWN];
    down_only  = btn_q[B_DOWN] & ~btn_q[B_UP];
    activity   = (|btn_rise) | btn_q[B_UP] | btn_q[B_DOWN];
    dir_rise   = up_only ? btn_rise[B_UP] : btn_rise[B_DOWN];

    state_d      = state_q;
    refresh_d    = '0;
    timeout_d    = '0;
    hold_d       = '0;
    pending_d    = pending_q;
    sel_d        = sel_q;
    rep_fire     = 1'b0;
    actualizar_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // An edit request (fresh, or deferred from a read) beats the refresh.
        if (pending_q || btn_rise[B_EDIT]) begin
          state_d   = EDIT;
          sel_d     = '0;
          pending_d = 1'b0;
        end else if (refresh_q == REF_LAST) begin
          state_d = READ;
        end else begin
          refresh_d = refresh_q + REF_W'(1);
        end
      end

      READ: begin
        pending_d = pending_q | btn_rise[B_EDIT];
        if (bus.RD_DONE) begin
          state_d      = IDLE;
          actualizar_d = 1'b1;
        end
      end

      EDIT: begin
        if (btn_rise[B_EDIT]) begin
          state_d = COMMIT;
        end else begin
          if (activity) begin
            if (btn_rise[B_NEXT]) begin
              sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
            end
          end else if (timeout_q == TMO_LAST) begin
            state_d = READ;
          end else begin
            timeout_d = timeout_q + TMO_W'(1);
          end

          // Repeat timer runs only while exactly one of UP/DOWN is held;
          // a fresh press fires at once, then every HOLD_CYCLES.
          if (up_only || down_only) begin
            if (dir_rise || (hold_q == HOLD_LAST)) begin
              rep_fire = 1'b1;
            end else begin
              hold_d = hold_q + HOLD_W'(1);
            end
          end
        end
      end

      COMMIT: begin
        if (bus.WR_ACK) begin
          state_d = READ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered versions of the next state, so they line up
    // with the state they describe.
    rd_req_d  = (state_d == READ);
    wr_req_d  = (state_d == COMMIT);
    editing_d = (state_d == EDIT) || (state_d == COMMIT);

    modificando_d = '0;
    for (int unsigned i = 0; i < N_FIELDS; i++) begin
      modificando_d[i] = (state_d == EDIT) && (sel_d == SEL_W'(i));
    end

    // A strobe is dropped when the field select moves in the same cycle.
    up_pulse_d   = rep_fire & up_only & ~btn_rise[B_NEXT];
    down_pulse_d = rep_fire & down_only & ~btn_rise[B_NEXT];
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state_q       <= IDLE;
      refresh_q     <= '0;
      hold_q        <= '0;
      timeout_q     <= '0;
      pending_q     <= 1'b0;
      sel_q         <= '0;
      // Both button stages load the live level so buttons held through
      // reset do not look like fresh presses afterwards.
      btn_q         <= btn_d;
      btn_prev_q    <= btn_d;
      rd_req_q      <= 1'b0;
      wr_req_q      <= 1'b0;
      actualizar_q  <= 1'b0;
      modificando_q <= '0;
      up_pulse_q    <= 1'b0;
      down_pulse_q  <= 1'b0;
      editing_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      refresh_q     <= refresh_d;
      hold_q        <= hold_d;
      timeout_q     <= timeout_d;
      pending_q     <= pending_d;
      sel_q         <= sel_d;
      btn_q         <= btn_d;
      btn_prev_q    <= btn_prev_d;
      rd_req_q      <= rd_req_d;
      wr_req_q      <= wr_req_d;
      actualizar_q  <= actualizar_d;
      modificando_q <= modificando_d;
      up_pulse_q    <= up_pulse_d;
      down_pulse_q  <= down_pulse_d;
      editing_q     <= editing_d;
    end
  end

  assign bus.RD_REQ      = rd_req_q;
  assign bus.WR_REQ      = wr_req_q;
  assign bus.ACTUALIZAR  = actualizar_q;
  assign bus.MODIFICANDO = modificando_q;
  assign bus.UP_PULSE    = up_pulse_q;
  assign bus.DOWN_PULSE  = down_pulse_q;
  assign bus.EDITING     = editing_q;

endmodule

// File: tb/tb_rtc_edit_sequencer.sv
// Bench for rtc_edit_sequencer: directed scenarios with literal expectations,
// then randomized buttons / bus responses, all compared every cycle against
// an event-level model of the sequencer.
module tb_rtc_edit_sequencer;

  localparam int N = 3;
  localparam int R = 8;
  localparam int H = 4;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic b_edit = 1'b0, b_next = 1'b0, b_up = 1'b0, b_dn = 1'b0;
  logic rd_done = 1'b0, wr_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  rtc_edit_sequencer_if #(.N_FIELDS(N)) bus ();

  assign bus.BTN_EDIT = b_edit;
  assign bus.BTN_NEXT = b_next;
  assign bus.BTN_UP   = b_up;
  assign bus.BTN_DOWN = b_dn;
  assign bus.RD_DONE  = rd_done;
  assign bus.WR_ACK   = wr_ack;

  rtc_edit_sequencer #(
    .N_FIELDS(N),
    .REFRESH_CYCLES(R),
    .HOLD_CYCLES(H),
    .EDIT_TIMEOUT(T)
  ) dut (
    .CLK(clk),
    .RESET_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // mode: "run", "fetch" (read pending), "edit", "store" (write pending)
  string    m_mode = "run";
  int       m_idle = 0;      // edges spent in run mode
  int       m_quiet = 0;     // consecutive edges without activity in edit
  int       m_field = 0;
  int       m_run = 0;       // length of current single-direction hold
  int       m_dir = 0;
  bit       m_run_edge = 1'b0;
  bit       m_pending = 1'b0;
  bit       e_act = 1'b0, e_up = 1'b0, e_dn = 1'b0;
  bit [3:0] raw1 = '0, raw2 = '0;
  bit       after_reset = 1'b1;
  bit       model_live = 1'b0;

  always @(posedge clk) begin
    bit [3:0] raw_now;
    bit [3:0] rise;
    bit [3:0] lvl;
    int       dir;
    bit       fire;
    raw_now = {b_dn, b_up, b_next, b_edit};
    rise    = after_reset ? 4'b0000 : (raw1 & ~raw2);
    lvl     = raw1;
    e_act = 1'b0; e_up = 1'b0; e_dn = 1'b0;
    if (!rst_n) begin
      m_mode = "run"; m_idle = 0; m_quiet = 0; m_field = 0;
      m_run = 0; m_pending = 1'b0; after_reset = 1'b1;
    end else begin
      after_reset = 1'b0;
      if (m_mode == "run") begin
        if (m_pending || rise[0]) begin
          m_mode = "edit"; m_field = 0; m_quiet = 0; m_pending = 1'b0;
        end else begin
          m_idle++;
          if (m_idle == R) begin m_mode = "fetch"; m_idle = 0; end
        end
      end else if (m_mode == "fetch") begin
        if (rise[0]) m_pending = 1'b1;
        if (rd_done) begin m_mode = "run"; m_idle = 0; e_act = 1'b1; end
      end else if (m_mode == "store") begin
        if (wr_ack) m_mode = "fetch";
      end else begin
        if (rise[0]) begin
          m_mode = "store";
        end else begin
          if (rise != 0 || lvl[2] || lvl[3]) begin
            m_quiet = 0;
            if (rise[1]) m_field = (m_field + 1) % N;
          end else begin
            m_quiet++;
            if (m_quiet == T) m_mode = "fetch";
          end
          dir = (lvl[2] && !lvl[3]) ? 1 : (lvl[3] && !lvl[2]) ? 2 : 0;
          if (dir == 0) begin
            m_run = 0;
          end else begin
            if (m_run == 0 || dir != m_dir) begin
              m_dir = dir; m_run = 1;
              m_run_edge = (dir == 1) ? rise[2] : rise[3];
            end else begin
              m_run++;
            end
            fire = m_run_edge ? ((m_run - 1) % H == 0) : (m_run % H == 0);
            if (fire && !rise[1]) begin
              if (dir == 1) e_up = 1'b1; else e_dn = 1'b1;
            end
          end
        end
      end
      if (m_mode != "edit") m_run = 0;
    end
    raw2 = raw1;
    raw1 = raw_now;
    model_live = 1'b1;
  end

  // ---------------- checking ----------------
  function automatic logic [8:0] dut_vec();
    return {bus.RD_REQ, bus.WR_REQ, bus.ACTUALIZAR, bus.UP_PULSE,
            bus.DOWN_PULSE, bus.EDITING, bus.MODIFICANDO};
  endfunction

  function automatic logic [8:0] model_vec();
    logic [2:0] mod;
    mod = (m_mode == "edit") ? 3'(1 << m_field) : 3'b000;
    return {(m_mode == "fetch"), (m_mode == "store"), e_act, e_up, e_dn,
            (m_mode == "edit" || m_mode == "store"), mod};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
    end
  endtask

  // Advance to the next falling edge and compare the DUT with the model.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (model_live) chk("cycle_vs_model", 32'(dut_vec()), 32'(model_vec()));
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    tick(n);
    rst_n = 1'b1;
  endtask

  initial begin
    int         cnt;
    logic [2:0] next_exp [3];
    next_exp[0] = 3'b010; next_exp[1] = 3'b100; next_exp[2] = 3'b001;

    // 1: reset with every button held
    b_edit = 1'b1; b_next = 1'b1; b_up = 1'b1; b_dn = 1'b1;
    do_reset(3);
    chk("reset_outputs", 32'(dut_vec()), 32'h0);
    tick(2);
    chk("held_after_reset_editing", 32'(bus.EDITING), 32'h0);
    chk("held_after_reset_pulses", 32'({bus.UP_PULSE, bus.DOWN_PULSE}), 32'h0);
    b_edit = 1'b0; b_next = 1'b0; b_up = 1'b0; b_dn = 1'b0;

    // 2: refresh period
    do_reset(2);
    tick(7);
    chk("refresh_not_yet", 32'(bus.RD_REQ), 32'h0);
    tick(1);
    chk("refresh_rd_req", 32'(bus.RD_REQ), 32'h1);
    tick(2);
    chk("rd_req_held", 32'(bus.RD_REQ), 32'h1);
    rd_done = 1'b1;
    tick(1);
    rd_done = 1'b0;
    chk("rd_done_rd_req", 32'(bus.RD_REQ), 32'h0);
    chk("rd_done_actualizar", 32'(bus.ACTUALIZAR), 32'h1);
    tick(1);
    chk("actualizar_one_cycle", 32'(bus.ACTUALIZAR), 32'h0);

    // 3: edit entry, field selection, commit
    b_edit = 1'b1;
    tick(2);
    chk("edit_entry_mod", 32'(bus.MODIFICANDO), 32'h1);
    chk("edit_entry_editing", 32'(bus.EDITING), 32'h1);
    b_edit = 1'b0;
    tick(1);
    for (int p = 0; p < 3; p++) begin
      b_next = 1'b1;
      tick(2);
      chk("next_select", 32'(bus.MODIFICANDO), 32'(next_exp[p]));
      b_next = 1'b0;
      tick(1);
    end
    b_edit = 1'b1;
    tick(2);
    b_edit = 1'b0;
    chk("commit_mod", 32'(bus.MODIFICANDO), 32'h0);
    chk("commit_wr_req", 32'(bus.WR_REQ), 32'h1);
    chk("commit_editing", 32'(bus.EDITING), 32'h1);
    tick(2);
    chk("wr_req_held", 32'(bus.WR_REQ), 32'h1);
    wr_ack = 1'b1;
    tick(1);
    wr_ack = 1'b0;
    chk("wr_ack_reqs", 32'({bus.RD_REQ, bus.WR_REQ}), 32'h2);

    // 5: edit press while a read is outstanding
    b_edit = 1'b1;
    tick(2);
    b_edit = 1'b0;
    chk("pending_still_reading", 32'({bus.RD_REQ, bus.MODIFICANDO}), 32'h8);
    tick(1);
    rd_done = 1'b1;
    tick(1);
    rd_done = 1'b0;
    chk("pending_actualizar", 32'({bus.ACTUALIZAR, bus.MODIFICANDO}), 32'h8);
    tick(1);
    chk("pending_enters_edit", 32'({bus.ACTUALIZAR, bus.MODIFICANDO}), 32'h1);

    // 4: auto-repeat, then both held, then a single DOWN press
    cnt = 0;
    b_up = 1'b1;
    for (int c = 0; c < 13; c++) begin tick(1); cnt += int'(bus.UP_PULSE); end
    b_up = 1'b0;
    for (int c = 0; c < 3; c++) begin tick(1); cnt += int'(bus.UP_PULSE); end
    chk("up_repeat_count", 32'(cnt), 32'd4);
    cnt = 0;
    b_up = 1'b1; b_dn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      cnt += int'(bus.UP_PULSE) + int'(bus.DOWN_PULSE);
    end
    b_up = 1'b0; b_dn = 1'b0;
    tick(3);
    chk("up_down_both_none", 32'(cnt), 32'd0);
    b_dn = 1'b1;
    tick(2);
    chk("down_pulse", 32'(bus.DOWN_PULSE), 32'h1);
    tick(1);
    chk("down_pulse_single", 32'(bus.DOWN_PULSE), 32'h0);
    b_dn = 1'b0;

    // 6: edit timeout, then reset while committing
    tick(16);
    chk("timeout_not_yet", 32'({bus.RD_REQ, bus.MODIFICANDO}), 32'h1);
    tick(1);
    chk("timeout_read", 32'({bus.RD_REQ, bus.EDITING, bus.MODIFICANDO}), 32'h10);
    rd_done = 1'b1;
    tick(1);
    rd_done = 1'b0;
    tick(1);
    b_edit = 1'b1;
    tick(2);
    b_edit = 1'b0;
    tick(1);
    b_edit = 1'b1;
    tick(2);
    b_edit = 1'b0;
    chk("commit_before_reset", 32'(bus.WR_REQ), 32'h1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("reset_in_commit", 32'(dut_vec()), 32'h0);

    // randomized phase with an automatic bus controller
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(15) == 0) b_edit = ~b_edit;
      if ($urandom_range(7) == 0)  b_next = ~b_next;
      if ($urandom_range(11) == 0) b_up = ~b_up;
      if ($urandom_range(11) == 0) b_dn = ~b_dn;
      rd_done = bus.RD_REQ ? ($urandom_range(3) == 0) : ($urandom_range(31) == 0);
      wr_ack  = bus.WR_REQ ? ($urandom_range(3) == 0) : ($urandom_range(31) == 0);
      rst_n   = ($urandom_range(599) != 0);
      tick(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
